waveform_table_controller: RTL and testbench
============================================

// Module: waveform_table_controller
// PURPOSE
//   Owns the quarter-wave sine RAM used by waveform generation; replaces the boot-time ROM image.
//   Accepts the table from an external loader over a valid/ready stream, then serves 1-cycle reads
//   to the waveform pipeline. Mutes the voice pipeline until a complete, valid table is resident.
//   Sequences reloads so muting starts and ends only at frame boundaries (operator ID 0).
// PARAMETERS
//   ADDR_WIDTH    14  table index width; depth = 2**ADDR_WIDTH entries
//   DATA_WIDTH    15  unsigned quarter-wave sample width
//   FLUSH_CYCLES  4   cycles held muted after arming, before loading starts; must be >= 1
// PORTS
//   i_Clock           in   1           system clock
//   i_Reset           in   1           synchronous, active-high reset
//   i_LoadValid       in   1           loader has a sample on i_LoadData
//   i_LoadData        in   DATA_WIDTH  next sample, addresses 0..depth-1 in order
//   o_LoadReady       out  1           controller accepts a sample this cycle
//   i_ReloadRequest   in   1           one-cycle pulse: replace the table
//   i_VoiceOperator   in   VoiceOperatorID_t  current pipeline slot, for frame alignment
//   i_ReadAddress     in   ADDR_WIDTH  waveform pipeline table index
//   o_ReadData        out  DATA_WIDTH  table sample, one cycle after i_ReadAddress
//   o_TableReady      out  1           resident table is complete and valid
//   o_Mute            out  1           downstream forces output to zero while high
//   o_LoadError       out  1           sticky: non-monotonic table detected
// BEHAVIOUR
//   Reset values: state LOADING, address counter 0, o_LoadReady=0 in the reset cycle,
//     o_ReadData=0, o_TableReady=0, o_Mute=1, o_LoadError=0. All outputs are registered.
//   States: LOADING, UNMUTE_WAIT, RUNNING, ARM, FLUSH, FAULT.
//   LOADING:
//     - o_LoadReady=1; a transfer occurs on i_LoadValid && o_LoadReady.
//     - Each transfer writes RAM[addr]=i_LoadData and increments addr.
//     - If a sample is less than the previous one (addr>0), set o_LoadError.
//       The load continues to the end.
//     - Transfer at addr=depth-1: o_LoadReady=0 from the next cycle. Go to FAULT if o_LoadError
//       (including an error on this final sample), else UNMUTE_WAIT.
//     - addr does not wrap inside LOADING.
//   UNMUTE_WAIT: o_TableReady=1 next cycle. On i_VoiceOperator==0, o_Mute=0 next cycle and go to
//     RUNNING.
//   RUNNING: on i_ReloadRequest go to ARM.
//   ARM: on i_VoiceOperator==0, o_Mute=1 and o_TableReady=0 next cycle and go to FLUSH.
//   FLUSH: hold FLUSH_CYCLES cycles, then go to LOADING with addr=0 and o_LoadError cleared.
//   FAULT: o_Mute=1, o_TableReady=0. i_ReloadRequest goes straight to FLUSH.
//   i_ReloadRequest is ignored in LOADING, UNMUTE_WAIT, ARM and FLUSH; it is not queued.
//   Read port:
//     - o_ReadData <= RAM[i_ReadAddress] in RUNNING and UNMUTE_WAIT; otherwise o_ReadData <= 0.
//     - Latency is exactly 1 cycle.
//     - RAM writes occur only in LOADING, so read/write collision is impossible.
//   Reset mid-load or mid-run: returns to LOADING at addr 0; prior RAM contents are discarded
//     (o_TableReady=0).
//   If i_LoadValid is low, no state changes in LOADING; stalls of any length are legal.
// STRUCTURE
//   synth.svh: add WAVE_TABLE_ADDR_WIDTH=14, WAVE_TABLE_DATA_WIDTH=15 and
//     WaveTableState_t enum; reuse VoiceOperatorID_t.
//   Sub-module waveform_table_ram: simple dual-port RAM, one write port and one registered read
//     port, inferable as block RAM.
//   The controller FSM, address counter, flush counter and monotonic check live in this module.
// TESTING
//   1. Reset, stream ramp 0..16383 with no stalls.
//      -> o_LoadReady falls after the 16384th beat.
//      -> o_Mute falls the cycle after the next i_VoiceOperator==0.
//      -> Read addr 100 returns 100 one cycle later.
//   2. Same load with random i_LoadValid gaps (~30% idle).
//      -> Identical RAM contents; no beat is lost or duplicated.
//   3. Load where sample 5000 equals sample 4999 minus 1.
//      -> o_LoadError=1; o_TableReady stays 0; o_Mute stays 1 (FAULT).
//      -> i_ReloadRequest clears o_LoadError after the FLUSH period.
//   4. In RUNNING, pulse i_ReloadRequest while i_VoiceOperator=7.
//      -> o_Mute rises the cycle after operator 0.
//      -> o_LoadReady rises FLUSH_CYCLES cycles later, with addr at 0.
//   5. Assert i_Reset at load beat 8000.
//      -> All outputs return to reset values.
//      -> The next load starts at address 0 and a full 16384 beats are required.
//   6. Pulse i_ReloadRequest during LOADING and during ARM.
//      -> Ignored; exactly one reload sequence occurs.

Source files
------------

// File: rtl/waveform_table_controller_pkg.sv
// Shared widths and types for the quarter-wave sine table controller.
package waveform_table_controller_pkg;

    localparam int WAVE_TABLE_ADDR_WIDTH = 14;
    localparam int WAVE_TABLE_DATA_WIDTH = 15;
    localparam int VOICE_OPERATOR_WIDTH  = 5;

    typedef logic [VOICE_OPERATOR_WIDTH-1:0] VoiceOperatorID_t;

    typedef enum logic [2:0] {
        LOADING,
        UNMUTE_WAIT,
        RUNNING,
        ARM,
        FLUSH,
        FAULT
    } WaveTableState_t;

endpackage

// File: rtl/waveform_table_ram.sv
// Simple dual-port table RAM: one write port, one registered read port.
module waveform_table_ram #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (write_en) mem[write_addr] <= write_data;
    end

    // Output register clears when reads are disabled, so no table data leaks while muted.
    always_ff @(posedge clk) begin
        if (read_en) read_data <= mem[read_addr];
        else         read_data <= '0;
    end

endmodule

// File: rtl/waveform_table_controller.sv
// Loads the quarter-wave sine table over a valid/ready stream and serves reads,
// muting the voice pipeline until a complete monotonic table is resident.
module waveform_table_controller
    import waveform_table_controller_pkg::*;
#(
    parameter int ADDR_WIDTH   = WAVE_TABLE_ADDR_WIDTH,
    parameter int DATA_WIDTH   = WAVE_TABLE_DATA_WIDTH,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_LoadValid,
    input  logic [DATA_WIDTH-1:0] i_LoadData,
    output logic                  o_LoadReady,
    input  logic                  i_ReloadRequest,
    input  VoiceOperatorID_t      i_VoiceOperator,
    input  logic [ADDR_WIDTH-1:0] i_ReadAddress,
    output logic [DATA_WIDTH-1:0] o_ReadData,
    output logic                  o_TableReady,
    output logic                  o_Mute,
    output logic                  o_LoadError
);

    localparam int FLUSH_WIDTH = $clog2(FLUSH_CYCLES + 1);

    WaveTableState_t state, next_state;

    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  prev_sample;
    logic [FLUSH_WIDTH-1:0] flush_count;
    logic transfer, last_beat, sample_error, flush_done, frame_start;
    logic next_mute, next_table_ready, read_en;

    assign frame_start  = i_VoiceOperator == '0;
    assign transfer     = (state == LOADING) && i_LoadValid && o_LoadReady;
    assign last_beat    = &addr;
    assign sample_error = transfer && (addr != '0) && (i_LoadData < prev_sample);
    assign flush_done   = flush_count == FLUSH_WIDTH'(FLUSH_CYCLES - 1);
    assign read_en      = !i_Reset && (state == RUNNING || state == UNMUTE_WAIT);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) state <= LOADING;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            LOADING: begin
                if (transfer && last_beat)
                    next_state = (o_LoadError || sample_error) ? FAULT : UNMUTE_WAIT;
            end
            UNMUTE_WAIT: if (frame_start) next_state = RUNNING;
            RUNNING:     if (i_ReloadRequest) next_state = ARM;
            ARM:         if (frame_start) next_state = FLUSH;
            FLUSH:       if (flush_done) next_state = LOADING;
            FAULT:       if (i_ReloadRequest) next_state = FLUSH;
            default:     next_state = LOADING;
        endcase
    end

    always_comb begin
        next_mute        = 1'b1;
        next_table_ready = 1'b0;
        unique case (state)
            UNMUTE_WAIT: begin
                next_table_ready = 1'b1;
                next_mute        = !frame_start;
            end
            RUNNING: begin
                next_table_ready = 1'b1;
                next_mute        = 1'b0;
            end
            ARM: begin
                next_table_ready = !frame_start;
                next_mute        = frame_start;
            end
            default: begin
                next_table_ready = 1'b0;
                next_mute        = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            addr         <= '0;
            prev_sample  <= '0;
            flush_count  <= '0;
            o_LoadReady  <= 1'b0;
            o_TableReady <= 1'b0;
            o_Mute       <= 1'b1;
            o_LoadError  <= 1'b0;
        end else begin
            o_LoadReady  <= next_state == LOADING;
            o_TableReady <= next_table_ready;
            o_Mute       <= next_mute;
            if (transfer) begin
                prev_sample <= i_LoadData;
                if (!last_beat) addr <= addr + 1'b1;
            end
            if (sample_error) o_LoadError <= 1'b1;
            // Leaving FLUSH starts a fresh load from address 0 with a clean error flag.
            if (state == FLUSH) begin
                flush_count <= flush_count + 1'b1;
                if (flush_done) begin
                    addr        <= '0;
                    o_LoadError <= 1'b0;
                end
            end else begin
                flush_count <= '0;
            end
        end
    end

    waveform_table_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk        (i_Clock),
        .write_en   (transfer),
        .write_addr (addr),
        .write_data (i_LoadData),
        .read_en    (read_en),
        .read_addr  (i_ReadAddress),
        .read_data  (o_ReadData)
    );

endmodule

// File: tb/tb_waveform_table_controller.sv
// Directed bench for the waveform table controller, using a 256-entry table
// so full loads stay short.
module tb_waveform_table_controller;

    localparam int AW    = 8;
    localparam int DW    = 15;
    localparam int FC    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          reload;
    logic [4:0]    op;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          table_ready;
    logic          mute;
    logic          load_error;

    logic [DW-1:0] tbl [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    waveform_table_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FLUSH_CYCLES(FC)
    ) dut (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_LoadValid     (load_valid),
        .i_LoadData      (load_data),
        .o_LoadReady     (load_ready),
        .i_ReloadRequest (reload),
        .i_VoiceOperator (op),
        .i_ReadAddress   (rd_addr),
        .o_ReadData      (rd_data),
        .o_TableReady    (table_ready),
        .o_Mute          (mute),
        .o_LoadError     (load_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        reload = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < DEPTH; i++) tbl[i] = DW'(i);
    endtask

    task automatic stream(input int first, input int count, input bit gaps, output bit ok);
        int idx;
        int budget;
        bit take;
        idx = first;
        budget = count * 10 + 20;
        while (idx < first + count && budget > 0) begin
            load_valid = gaps ? ($urandom_range(0, 9) >= 3) : 1'b1;
            load_data = tbl[idx];
            take = load_valid && load_ready;
            tick();
            if (take) idx++;
            budget--;
        end
        load_valid = 1'b0;
        ok = (idx == first + count);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        reload = 1'b0;
        op = 5'd3;
        rd_addr = '0;
        tick();
        tick();
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", load_ready); end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL rst_rdata: got %0d want 0", rd_data); end
        checks++;
        if (table_ready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", table_ready); end
        checks++;
        if (mute !== 1'b1) begin errors++; $display("FAIL rst_mute: got %b want 1", mute); end
        checks++;
        if (load_error !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", load_error); end
        rst = 1'b0;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b want 1", load_ready); end
    endtask

    task automatic test_ramp_load();
        bit ok;
        fill_ramp();
        op = 5'd3;
        stream(0, DEPTH, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ramp_stream: got timeout want %0d beats", DEPTH); end
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL ramp_ready_fall: got %b want 0", load_ready); end
        checks++;
        if (mute !== 1'b1) begin errors++; $display("FAIL ramp_mute_hold: got %b want 1", mute); end
        tick();
        checks++;
        if (table_ready !== 1'b1) begin errors++; $display("FAIL ramp_tready: got %b want 1", table_ready); end
        checks++;
        if (mute !== 1'b1) begin errors++; $display("FAIL ramp_mute_op3: got %b want 1", mute); end
        op = 5'd0;
        tick();
        op = 5'd1;
        checks++;
        if (mute !== 1'b0) begin errors++; $display("FAIL ramp_unmute: got %b want 0", mute); end
        rd_addr = AW'(100);
        tick();
        checks++;
        if (rd_data !== DW'(100)) begin errors++; $display("FAIL ramp_read100: got %0d want 100", rd_data); end
    endtask

    task automatic test_reload_sequence();
        bit early;
        op = 5'd7;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        tick();
        checks++;
        if (mute !== 1'b0 || table_ready !== 1'b1) begin
            errors++;
            $display("FAIL arm_wait: got mute=%b tready=%b want 0/1", mute, table_ready);
        end
        op = 5'd0;
        tick();
        op = 5'd7;
        checks++;
        if (mute !== 1'b1 || table_ready !== 1'b0) begin
            errors++;
            $display("FAIL arm_mute: got mute=%b tready=%b want 1/0", mute, table_ready);
        end
        early = 1'b0;
        for (int k = 1; k < FC; k++) begin
            tick();
            if (load_ready !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL flush_early: got ready=1 want 0 before %0d cycles", FC); end
        tick();
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", load_ready); end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL flush_rdata: got %0d want 0", rd_data); end
    endtask

    task automatic test_gapped_load();
        bit ok;
        for (int i = 0; i < DEPTH; i++) tbl[i] = DW'(i * 100);
        op = 5'd2;
        stream(0, DEPTH, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gap_stream: got timeout want %0d beats", DEPTH); end
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL gap_ready_fall: got %b want 0", load_ready); end
        op = 5'd0;
        tick();
        op = 5'd2;
        checks++;
        if (mute !== 1'b0) begin errors++; $display("FAIL gap_unmute: got %b want 0", mute); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            tick();
            checks++;
            if (rd_data !== DW'(i * 100)) begin
                errors++;
                $display("FAIL gap_read[%0d]: got %0d want %0d", i, rd_data, i * 100);
            end
        end
    endtask

    task automatic test_ignored_reload();
        bit ok;
        bit bad;
        op = 5'd7;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        op = 5'd0;
        tick();
        op = 5'd7;
        checks++;
        if (mute !== 1'b1) begin errors++; $display("FAIL ign_mute: got %b want 1", mute); end
        tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL ign_flush3: got %b want 0", load_ready); end
        tick();
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL ign_flush4: got %b want 1", load_ready); end
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || mute !== 1'b1) begin
            errors++;
            $display("FAIL ign_loading: got ready=%b mute=%b want 1/1", load_ready, mute);
        end
        fill_ramp();
        stream(0, DEPTH, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ign_stream: got timeout want %0d beats", DEPTH); end
        op = 5'd0;
        tick();
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            op = 5'(k % 8);
            tick();
            if (load_ready !== 1'b0 || mute !== 1'b0 || table_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL ign_extra_reload: got second reload want one sequence"); end
    endtask

    task automatic test_load_error();
        bit ok;
        do_reset();
        fill_ramp();
        tbl[200] = DW'(198);
        op = 5'd0;
        stream(0, 201, 1'b0, ok);
        checks++;
        if (load_error !== 1'b1 || load_ready !== 1'b1 || !ok) begin
            errors++;
            $display("FAIL err_detect: got err=%b ready=%b ok=%b want 1/1/1", load_error, load_ready, ok);
        end
        stream(201, DEPTH - 201, 1'b0, ok);
        checks++;
        if (load_ready !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL err_finish: got ready=%b ok=%b want 0/1", load_ready, ok);
        end
        rd_addr = AW'(100);
        tick();
        tick();
        tick();
        checks++;
        if (mute !== 1'b1 || table_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_fault: got mute=%b tready=%b want 1/0", mute, table_ready);
        end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL err_rdata: got %0d want 0", rd_data); end
        op = 5'd7;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (load_error !== 1'b1) begin errors++; $display("FAIL err_hold_flush: got %b want 1", load_error); end
        tick();
        checks++;
        if (load_error !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got err=%b ready=%b want 0/1", load_error, load_ready);
        end
        fill_ramp();
        tbl[DEPTH-1] = DW'(DEPTH - 3);
        stream(0, DEPTH - 1, 1'b0, ok);
        checks++;
        if (load_error !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL err_last_pre: got err=%b ok=%b want 0/1", load_error, ok);
        end
        stream(DEPTH - 1, 1, 1'b0, ok);
        checks++;
        if (load_error !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_last: got err=%b ready=%b want 1/0", load_error, load_ready);
        end
        op = 5'd0;
        tick();
        tick();
        checks++;
        if (mute !== 1'b1 || table_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_last_fault: got mute=%b tready=%b want 1/0", mute, table_ready);
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        do_reset();
        fill_ramp();
        op = 5'd4;
        stream(0, DEPTH / 2, 1'b0, ok);
        load_valid = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b0 || table_ready !== 1'b0 || mute !== 1'b1 ||
            load_error !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b tready=%b mute=%b err=%b rdata=%0d want 0/0/1/0/0",
                     load_ready, table_ready, mute, load_error, rd_data);
        end
        rst = 1'b0;
        load_valid = 1'b0;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", load_ready); end
        for (int i = 0; i < DEPTH; i++) tbl[i] = DW'(i * 2 + 1);
        stream(0, DEPTH - 1, 1'b0, ok);
        checks++;
        if (load_ready !== 1'b1 || table_ready !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL mid_full_len: got ready=%b tready=%b ok=%b want 1/0/1", load_ready, table_ready, ok);
        end
        stream(DEPTH - 1, 1, 1'b0, ok);
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", load_ready); end
        op = 5'd0;
        tick();
        op = 5'd4;
        rd_addr = '0;
        tick();
        checks++;
        if (rd_data !== DW'(1)) begin errors++; $display("FAIL mid_read0: got %0d want 1", rd_data); end
        rd_addr = AW'(DEPTH - 1);
        tick();
        checks++;
        if (rd_data !== DW'(2 * DEPTH - 1)) begin
            errors++;
            $display("FAIL mid_readlast: got %0d want %0d", rd_data, 2 * DEPTH - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ramp_load();
        test_reload_sequence();
        test_gapped_load();
        test_ignored_reload();
        test_load_error();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
